// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: owns the PC, issues in-order memory
// requests, queues returned instructions for decode, and flushes on redirect.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready
);

  localparam int              AW     = $clog2(DEPTH);
  localparam int              CW     = AW + 1;
  localparam logic [CW:0]     LIMIT  = DEPTH[CW:0];
  localparam logic [XLEN-1:0] STEP_W = XLEN'(PC_STEP);

  logic [XLEN-1:0]  pc;
  logic [AW-1:0]    alloc_ptr;
  logic [AW-1:0]    fill_ptr;
  logic [AW-1:0]    head_ptr;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    pend;
  logic [CW-1:0]    drop_cnt;
  logic [DEPTH-1:0] slot_filled;
  logic [XLEN-1:0]  slot_pc    [DEPTH];
  logic [ILEN-1:0]  slot_instr [DEPTH];

  logic req_fire;
  logic resp_take;
  logic resp_drop;
  logic pop;

  // Stale responses still owed count against the issue budget, so the memory
  // never has more than DEPTH requests in flight.
  assign imem_req_valid = reset && !redirect_valid &&
                          (({1'b0, occ} + {1'b0, drop_cnt}) < LIMIT);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop = imem_resp_valid && (drop_cnt != '0);
  assign resp_take = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;

  assign out_valid = slot_filled[head_ptr] && (occ != '0) && !redirect_valid;
  assign out_instr = slot_instr[head_ptr];
  assign out_pc    = slot_pc[head_ptr];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc          <= RESET_PC;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      occ         <= '0;
      pend        <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      occ         <= '0;
      pend        <= '0;
      slot_filled <= '0;
      // Every unfilled request is now owed as a stale response, minus one
      // arriving right now.
      drop_cnt    <= drop_cnt + pend - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        slot_filled[alloc_ptr] <= 1'b0;
        alloc_ptr              <= alloc_ptr + AW'(1);
        pc                     <= pc + STEP_W;
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (resp_take) begin
        slot_filled[fill_ptr] <= 1'b1;
        fill_ptr              <= fill_ptr + AW'(1);
      end
      if (pop) begin
        slot_filled[head_ptr] <= 1'b0;
        head_ptr              <= head_ptr + AW'(1);
      end
      occ  <= occ + CW'(req_fire) - CW'(pop);
      pend <= pend + CW'(req_fire) - CW'(resp_take);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      slot_pc[alloc_ptr] <= pc;
    end
    if (resp_take) begin
      slot_instr[fill_ptr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency in-order memory model.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  int          req_fires = 0;
  int          fires0;
  int          n;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ordy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ordy;
    #1;
  endtask

  // One clock cycle: log what the memory sees this cycle, then present the
  // next due response just after the following falling edge.
  task automatic tick();
    #1;
    if (!reset) begin
      q_addr.delete();
      q_due.delete();
    end else begin
      if (imem_resp_valid && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        q_addr.push_back(imem_req_addr);
        q_due.push_back(cyc + lat);
        req_fires++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = instr_of(q_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset           = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Reset behaviour and streaming with a one-cycle memory
    lat = 1;
    tick();
    tick();
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("rel_req_addr", imem_req_addr, 32'h0);
    tick();
    checkOutput("first_out_valid", 32'(out_valid), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      checkOutput("stream_valid", 32'(out_valid), 32'd1);
      checkOutput("stream_pc", out_pc, 32'(4 * k));
      checkOutput("stream_instr", out_instr, instr_of(32'(4 * k)));
      tick();
    end

    // Backpressure: exactly DEPTH requests, then drain in order
    applyStimulus(1'b0, 32'h0, 1'b0);
    doReset();
    fires0 = req_fires;
    repeat (6) tick();
    checkOutput("full_fires", 32'(req_fires - fires0), 32'd4);
    checkOutput("full_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("full_out_pc", out_pc, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("pop_cycle_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    checkOutput("resume_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("resume_req_addr", imem_req_addr, 32'h10);
    checkOutput("drain_pc1", out_pc, 32'h4);
    tick();
    checkOutput("drain_pc2", out_pc, 32'h8);
    tick();
    checkOutput("drain_pc3", out_pc, 32'hC);
    tick();
    checkOutput("refill_valid", 32'(out_valid), 32'd1);
    checkOutput("refill_pc", out_pc, 32'h10);
    checkOutput("refill_instr", out_instr, instr_of(32'h10));

    // Redirect with three requests in flight
    applyStimulus(1'b0, 32'h0, 1'b1);
    lat = 4;
    doReset();
    checkOutput("lat_req_addr", imem_req_addr, 32'h0);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 32'h100, 1'b1);
    checkOutput("redir_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("redir_out_valid", 32'(out_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("post_redir_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("post_redir_req_addr", imem_req_addr, 32'h100);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("redir_wait_cycles", 32'(n), 32'd5);
    checkOutput("redir_first_pc", out_pc, 32'h100);
    checkOutput("redir_first_instr", out_instr, instr_of(32'h100));

    // Redirect coinciding with a response and a would-be pop
    applyStimulus(1'b0, 32'h0, 1'b1);
    lat = 2;
    doReset();
    tick();
    tick();
    tick();
    checkOutput("pre_redir_valid", 32'(out_valid), 32'd1);
    checkOutput("pre_redir_pc", out_pc, 32'h0);
    applyStimulus(1'b1, 32'h200, 1'b1);
    checkOutput("redir_pop_blocked", 32'(out_valid), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir2_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("redir2_req_addr", imem_req_addr, 32'h200);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("redir2_wait_cycles", 32'(n), 32'd3);
    checkOutput("redir2_first_pc", out_pc, 32'h200);
    checkOutput("redir2_first_instr", out_instr, instr_of(32'h200));

    // PC wraps past the top of the address space
    applyStimulus(1'b0, 32'h0, 1'b1);
    lat = 1;
    doReset();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_addr_zero", imem_req_addr, 32'h0);
    tick();
    checkOutput("wrap_out_valid", 32'(out_valid), 32'd1);
    checkOutput("wrap_out_pc_top", out_pc, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_out_pc_zero", out_pc, 32'h0);
    checkOutput("wrap_out_instr_zero", out_instr, instr_of(32'h0));

    // Reset asserted with a full queue
    applyStimulus(1'b0, 32'h0, 1'b0);
    doReset();
    applyStimulus(1'b1, 32'h300, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    repeat (6) tick();
    checkOutput("mid_full_valid", 32'(out_valid), 32'd1);
    checkOutput("mid_full_pc", out_pc, 32'h300);
    checkOutput("mid_full_req_valid", 32'(imem_req_valid), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("mid_rel_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("mid_rel_req_addr", imem_req_addr, 32'h0);
    checkOutput("mid_rel_out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
